control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_PC_HOLD, default 1: number of cycles held in RESET_ST after reset_n deasserts, before FETCH0.
REQ-002 Ports: clk input 1 (single clock); reset_n input 1 (reset is asynchronous and active-low).
REQ-003 Ports: IR_Data input 32 (instruction register, opcode = IR_Data[31:27]); con_output input 1 (branch condition); stop input 1 (external halt request).
REQ-004 Ports: PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable, MAR_enable, MDR_enable, r_enable, con_enable, HI_enable, LO_enable output 1 each (datapath register loads).
REQ-005 Ports: read, write output 1 each (memory strobes); Gra, Grb, Grc, BAout output 1 each (register select/encode).
REQ-006 Ports: PC_select, Z_LO_select, Z_HI_select, MDR_select, c_select, r_select, HI_select, LO_select output 1 each (bus drivers); alu_instruction output 5 (ALU opcode).
REQ-007 Ports: run output 1 (high while executing, low in HALT_ST and RESET_ST).

Function
REQ-008 Moore FSM; one state per datapath step; state register advances on rising clk; all outputs decoded from current state only.
REQ-009 At most one bus driver (PC/Z_LO/Z_HI/MDR/c/r/HI/LO select) active in any state.
REQ-010 Fetch: FETCH0 PC_select+MAR_enable; FETCH1 PC_increment_enable+read+MDR_enable; FETCH2 MDR_select+IR_enable; FETCH2 -> decode on IR_Data[31:27] to first execute state.
REQ-011 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, mul 01111, div 10000, brx 10010, jr 10011, mfhi 11000, mflo 11001, nop 11010, halt 11011; ALU codes add 00001, sub 00010, and 00011, or 00100, mul 00101, div 00110.
REQ-012 Reg-reg ALU (add/sub/and/or), 3 exec cycles: T3 Grb+r_select+Y_enable; T4 Grc+r_select+alu_instruction+Z_enable; T5 Z_LO_select+Gra+r_enable.
REQ-013 addi/ldi: T3 Grb+BAout+Y_enable; T4 c_select+alu add+Z_enable; T5 Z_LO_select+Gra+r_enable (ldi with Rb=0 yields C).
REQ-014 ld: addi T3/T4, then T5 Z_LO_select+MAR_enable; T6 read+MDR_enable; T7 MDR_select+Gra+r_enable.
REQ-015 st: T3-T5 as ld; T6 Gra+r_select+MDR_enable; T7 write (MDR held).
REQ-016 mul/div: T3 Gra+r_select+Y_enable; T4 Grb+r_select+alu+Z_enable; T5 Z_LO_select+LO_enable; T6 Z_HI_select+HI_enable.
REQ-017 mfhi/mflo: T3 HI_select (resp. LO_select)+Gra+r_enable.
REQ-018 brx: T3 Gra+r_select+con_enable; T4 PC_select+Y_enable; T5 c_select+alu add+Z_enable; T6 Z_LO_select+PC_enable only if con_output=1 sampled in T6.
REQ-019 jr: T3 Gra+r_select+PC_enable. nop: no exec cycle, FETCH2 -> FETCH0.
REQ-020 Last exec state of every instruction -> FETCH0, or HALT_ST if stop=1 at that edge.
REQ-021 halt opcode or stop at an instruction boundary -> HALT_ST; HALT_ST all outputs 0, run=0; stop=0 while in HALT_ST -> FETCH0 next edge.
REQ-022 stop asserted mid-instruction does not abort; honoured at the instruction boundary.
REQ-023 Undefined opcode -> treated as nop (FETCH0 next).

Reset
REQ-024 reset_n=0 forces RESET_ST immediately (asynchronous), mid-instruction included; all outputs 0, alu_instruction 00000, run 0.
REQ-025 After reset_n rises, remain RESET_ST for RESET_PC_HOLD cycles, then FETCH0.

Structure
REQ-026 Opcode constants, ALU code constants and state enumeration in shared package cpu_ctrl_pkg; datapath uses same ALU codes.
REQ-027 Single module; no sub-modules; the state-to-output decode stays in one case statement.

Verification
REQ-028 reset_n low mid-FETCH1 -> all outputs 0 within same cycle; FETCH0 exactly RESET_PC_HOLD+1 edges after release.
REQ-029 IR=add R1,R2,R3 -> 6 cycles FETCH0..T5; T4 alu_instruction=00001, Grc=1; T5 Gra+r_enable+Z_LO_select.
REQ-030 IR=ldi R4,0x65 then mfhi, with datapath -> R4=0x65 after ldi; mfhi T3 HI_select+r_enable asserted one cycle.
REQ-031 brx with con_output=0 -> PC_enable never asserted; con_output=1 -> PC_enable in T6 only.
REQ-032 stop pulsed during mul T4 -> mul completes through T6 (HI_enable seen), then HALT_ST, run=0.
REQ-033 Every state: one-hot check that ≤1 bus select is high; halt opcode -> HALT_ST in the cycle after FETCH2.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU control path: opcodes, ALU operation codes and
// the control FSM state set. The datapath ALU decodes the same ALU codes.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BRX  = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00011;
  localparam logic [4:0] ALU_OR   = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b00101;
  localparam logic [4:0] ALU_DIV  = 5'b00110;

  // One state per datapath step; instruction classes own their T3..T7 steps.
  typedef enum logic [4:0] {
    RESET_ST, FETCH0, FETCH1, FETCH2, HALT_ST,
    ALU_T3, ALU_T4, ALU_T5,
    IMM_T3, IMM_T4, IMM_T5,
    LD_T3, LD_T4, LD_T5, LD_T6, LD_T7,
    ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
    MD_T3, MD_T4, MD_T5, MD_T6,
    MFHI_T3, MFLO_T3,
    BR_T3, BR_T4, BR_T5, BR_T6,
    JR_T3
  } state_t;

  // ALU operation for the opcodes whose execute step uses an opcode-specific op.
  function automatic logic [4:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      OP_MUL:  alu_code = ALU_MUL;
      OP_DIV:  alu_code = ALU_DIV;
      default: alu_code = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Moore control FSM for the multi-cycle CPU: sequences fetch, decode and the
// per-instruction execute steps, and drives the datapath load/select strobes.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  input  logic        stop,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        con_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        BAout,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        Z_HI_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic        HI_select,
  output logic        LO_select,
  output logic [4:0]  alu_instruction,
  output logic        run
);

  state_t      state;
  logic [15:0] hold_cnt;
  logic [4:0]  alu_op;        // ALU op captured at decode for reg-reg and mul/div
  logic        stop_pending;  // stop seen mid-instruction, honoured at boundary
  logic        halt_req;
  logic [4:0]  opcode;
  logic        unused_ir;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];
  assign halt_req  = stop | stop_pending;

  // State register, reset hold counter, decoded ALU op and latched halt request.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RESET_ST;
      hold_cnt     <= '0;
      alu_op       <= ALU_NONE;
      stop_pending <= 1'b0;
    end else begin
      if (state == HALT_ST || state == RESET_ST) stop_pending <= 1'b0;
      else if (stop)                             stop_pending <= 1'b1;

      case (state)
        RESET_ST: begin
          if (hold_cnt >= 16'(RESET_PC_HOLD)) state <= FETCH0;
          else                                hold_cnt <= hold_cnt + 16'd1;
        end
        FETCH0: state <= FETCH1;
        FETCH1: state <= FETCH2;
        FETCH2: begin
          alu_op <= alu_code(opcode);
          case (opcode)
            OP_LD:                          state <= LD_T3;
            OP_ST:                          state <= ST_T3;
            OP_LDI, OP_ADDI:                state <= IMM_T3;
            OP_ADD, OP_SUB, OP_AND, OP_OR:  state <= ALU_T3;
            OP_MUL, OP_DIV:                 state <= MD_T3;
            OP_BRX:                         state <= BR_T3;
            OP_JR:                          state <= JR_T3;
            OP_MFHI:                        state <= MFHI_T3;
            OP_MFLO:                        state <= MFLO_T3;
            OP_HALT:                        state <= HALT_ST;
            default:                        state <= halt_req ? HALT_ST : FETCH0;
          endcase
        end
        ALU_T3:  state <= ALU_T4;
        ALU_T4:  state <= ALU_T5;
        IMM_T3:  state <= IMM_T4;
        IMM_T4:  state <= IMM_T5;
        LD_T3:   state <= LD_T4;
        LD_T4:   state <= LD_T5;
        LD_T5:   state <= LD_T6;
        LD_T6:   state <= LD_T7;
        ST_T3:   state <= ST_T4;
        ST_T4:   state <= ST_T5;
        ST_T5:   state <= ST_T6;
        ST_T6:   state <= ST_T7;
        MD_T3:   state <= MD_T4;
        MD_T4:   state <= MD_T5;
        MD_T5:   state <= MD_T6;
        BR_T3:   state <= BR_T4;
        BR_T4:   state <= BR_T5;
        BR_T5:   state <= BR_T6;
        HALT_ST: if (!stop) state <= FETCH0;
        // Last execute step of every instruction is an instruction boundary.
        ALU_T5, IMM_T5, LD_T7, ST_T7, MD_T6, MFHI_T3, MFLO_T3, BR_T6, JR_T3:
          state <= halt_req ? HALT_ST : FETCH0;
        default: state <= RESET_ST;
      endcase
    end
  end

  // State-to-strobe decode; at most one bus driver is selected per state.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    PC_enable = 1'b0; PC_increment_enable = 1'b0; IR_enable = 1'b0;
    Y_enable = 1'b0; Z_enable = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0;
    r_enable = 1'b0; con_enable = 1'b0; HI_enable = 1'b0; LO_enable = 1'b0;
    read = 1'b0; write = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; BAout = 1'b0;
    PC_select = 1'b0; Z_LO_select = 1'b0; Z_HI_select = 1'b0; MDR_select = 1'b0;
    c_select = 1'b0; r_select = 1'b0; HI_select = 1'b0; LO_select = 1'b0;
    alu_instruction = ALU_NONE;
    run = 1'b1;
    case (state)
      RESET_ST, HALT_ST: run = 1'b0;
      FETCH0: begin PC_select = 1'b1; MAR_enable = 1'b1; end
      FETCH1: begin PC_increment_enable = 1'b1; read = 1'b1; MDR_enable = 1'b1; end
      FETCH2: begin MDR_select = 1'b1; IR_enable = 1'b1; end
      ALU_T3, MD_T3: begin
        if (state == ALU_T3) Grb = 1'b1; else Gra = 1'b1;
        r_select = 1'b1; Y_enable = 1'b1;
      end
      ALU_T4, MD_T4: begin
        if (state == ALU_T4) Grc = 1'b1; else Grb = 1'b1;
        r_select = 1'b1; alu_instruction = alu_op; Z_enable = 1'b1;
      end
      ALU_T5, IMM_T5: begin Z_LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
      IMM_T3, LD_T3, ST_T3: begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
      IMM_T4, LD_T4, ST_T4, BR_T5: begin
        c_select = 1'b1; alu_instruction = ALU_ADD; Z_enable = 1'b1;
      end
      LD_T5, ST_T5: begin Z_LO_select = 1'b1; MAR_enable = 1'b1; end
      LD_T6: begin read = 1'b1; MDR_enable = 1'b1; end
      LD_T7: begin MDR_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
      ST_T6: begin Gra = 1'b1; r_select = 1'b1; MDR_enable = 1'b1; end
      ST_T7: write = 1'b1;
      MD_T5: begin Z_LO_select = 1'b1; LO_enable = 1'b1; end
      MD_T6: begin Z_HI_select = 1'b1; HI_enable = 1'b1; end
      MFHI_T3: begin HI_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
      MFLO_T3: begin LO_select = 1'b1; Gra = 1'b1; r_enable = 1'b1; end
      BR_T3: begin Gra = 1'b1; r_select = 1'b1; con_enable = 1'b1; end
      BR_T4: begin PC_select = 1'b1; Y_enable = 1'b1; end
      BR_T6: begin Z_LO_select = 1'b1; PC_enable = con_output; end
      JR_T3: begin Gra = 1'b1; r_select = 1'b1; PC_enable = 1'b1; end
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe sequences for each
// instruction class, reset/stop/halt behaviour, and a small datapath model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] IR_Data;
  logic        con_output, stop;
  logic PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic MAR_enable, MDR_enable, r_enable, con_enable, HI_enable, LO_enable;
  logic read, write, Gra, Grb, Grc, BAout;
  logic PC_select, Z_LO_select, Z_HI_select, MDR_select, c_select, r_select;
  logic HI_select, LO_select, run;
  logic [4:0] alu_instruction;

  int checks = 0;
  int failures = 0;

  // Observed bundle: bit30 run, 29:25 ALU code, 24:17 bus selects, 16:0 strobes.
  localparam logic [30:0] PC_EN = 31'h1,      PC_INC = 31'h2,      IR_EN = 31'h4;
  localparam logic [30:0] Y_EN  = 31'h8,      Z_EN   = 31'h10,     MAR_EN = 31'h20;
  localparam logic [30:0] MDR_EN = 31'h40,    R_EN   = 31'h80,     CON_EN = 31'h100;
  localparam logic [30:0] HI_EN = 31'h200,    LO_EN  = 31'h400,    RD = 31'h800;
  localparam logic [30:0] WR    = 31'h1000,   GRA    = 31'h2000,   GRB = 31'h4000;
  localparam logic [30:0] GRC   = 31'h8000,   BAO    = 31'h10000,  S_PC = 31'h20000;
  localparam logic [30:0] S_ZLO = 31'h40000,  S_ZHI  = 31'h80000,  S_MDR = 31'h100000;
  localparam logic [30:0] S_C   = 31'h200000, S_R    = 31'h400000, S_HI = 31'h800000;
  localparam logic [30:0] S_LO  = 31'h1000000;
  localparam logic [30:0] A_ADD = 31'h2000000, A_MUL = 31'hA000000;
  localparam logic [30:0] RUN   = 31'h40000000;
  localparam logic [30:0] F0 = RUN | S_PC | MAR_EN;
  localparam logic [30:0] F1 = RUN | PC_INC | RD | MDR_EN;
  localparam logic [30:0] F2 = RUN | S_MDR | IR_EN;

  logic [30:0] obs;
  assign obs = {run, alu_instruction, LO_select, HI_select, r_select, c_select,
                MDR_select, Z_HI_select, Z_LO_select, PC_select, BAout, Grc, Grb,
                Gra, write, read, LO_enable, HI_enable, con_enable, r_enable,
                MDR_enable, MAR_enable, Z_enable, Y_enable, IR_enable,
                PC_increment_enable, PC_enable};

  control_unit #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .reset_n(reset_n), .IR_Data(IR_Data), .con_output(con_output),
    .stop(stop), .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .con_enable(con_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout),
    .PC_select(PC_select), .Z_LO_select(Z_LO_select), .Z_HI_select(Z_HI_select),
    .MDR_select(MDR_select), .c_select(c_select), .r_select(r_select),
    .HI_select(HI_select), .LO_select(LO_select),
    .alu_instruction(alu_instruction), .run(run)
  );

  always #5 clk = ~clk;

  // Minimal datapath driven by the strobes, used to see instruction results.
  logic [31:0] regs [16];
  logic [31:0] y_r, z_lo, z_hi, hi_r, lo_r, pc_r, mdr_r, bus, c_sext;
  logic [63:0] alu_res;
  logic [3:0]  rsel;
  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    hi_r = 32'h0000ABCD; lo_r = 32'h0; y_r = 32'h0; z_lo = 32'h0; z_hi = 32'h0;
    pc_r = 32'h0; mdr_r = 32'h0;
  end
  always_comb begin
    c_sext = {{13{IR_Data[18]}}, IR_Data[18:0]};
    rsel = Gra ? IR_Data[26:23] : Grb ? IR_Data[22:19] : Grc ? IR_Data[18:15] : 4'd0;
    bus = 32'h0;
    if (PC_select)          bus = pc_r;
    else if (Z_LO_select)   bus = z_lo;
    else if (Z_HI_select)   bus = z_hi;
    else if (MDR_select)    bus = mdr_r;
    else if (c_select)      bus = c_sext;
    else if (HI_select)     bus = hi_r;
    else if (LO_select)     bus = lo_r;
    else if (BAout)         bus = (rsel == 4'd0) ? 32'h0 : regs[rsel];
    else if (r_select)      bus = regs[rsel];
    case (alu_instruction)
      5'b00001: alu_res = {32'h0, y_r + bus};
      5'b00010: alu_res = {32'h0, y_r - bus};
      5'b00011: alu_res = {32'h0, y_r & bus};
      5'b00100: alu_res = {32'h0, y_r | bus};
      5'b00101: alu_res = y_r * bus;
      default:  alu_res = 64'h0;
    endcase
  end
  always @(posedge clk) begin
    if (Y_enable)   y_r <= bus;
    if (Z_enable)   begin z_lo <= alu_res[31:0]; z_hi <= alu_res[63:32]; end
    if (r_enable)   regs[rsel] <= bus;
    if (HI_enable)  hi_r <= bus;
    if (LO_enable)  lo_r <= bus;
    if (MDR_enable) mdr_r <= read ? 32'h0 : bus;
    if (PC_enable)  pc_r <= bus;
    else if (PC_increment_enable) pc_r <= pc_r + 32'd1;
  end

  // Every cycle: no more than one bus driver may be selected.
  always @(negedge clk) begin
    checks++;
    if ($countones(obs[24:17]) > 1) begin
      failures++;
      $display("FAIL bus_onehot: selects=%b required at most one set", obs[24:17]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; IR_Data = 32'h0; con_output = 1'b0; stop = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== 31'h0) begin
      failures++; $display("FAIL reset_outputs: got %h required %h", obs, 31'h0);
    end
    @(negedge clk); reset_n = 1'b1;
    tick();
    checks++;
    if (obs !== 31'h0) begin
      failures++; $display("FAIL reset_hold: got %h required %h", obs, 31'h0);
    end
    tick();
    checks++;
    if (obs !== F0) begin
      failures++; $display("FAIL reset_to_fetch0: got %h required %h", obs, F0);
    end
  endtask

  task automatic test_reg_alu();
    logic [30:0] seq [$];
    IR_Data = 32'h18918000;  // add R1,R2,R3
    seq = '{F1, F2, RUN|GRB|S_R|Y_EN, RUN|GRC|S_R|A_ADD|Z_EN, RUN|S_ZLO|GRA|R_EN, F0};
    foreach (seq[i]) begin
      tick(); checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL add step %0d: got %h required %h", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_ldi_mfhi();
    logic [30:0] seq [$];
    IR_Data = 32'h0A000065;  // ldi R4,0x65
    seq = '{F1, F2, RUN|GRB|BAO|Y_EN, RUN|S_C|A_ADD|Z_EN, RUN|S_ZLO|GRA|R_EN, F0};
    foreach (seq[i]) begin
      tick(); checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL ldi step %0d: got %h required %h", i, obs, seq[i]);
      end
    end
    checks++;
    if (regs[4] !== 32'h65) begin
      failures++; $display("FAIL ldi_r4: got %h required %h", regs[4], 32'h65);
    end
    IR_Data = 32'hC2800000;  // mfhi R5
    seq = '{F1, F2, RUN|S_HI|GRA|R_EN, F0};
    foreach (seq[i]) begin
      tick(); checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL mfhi step %0d: got %h required %h", i, obs, seq[i]);
      end
    end
    checks++;
    if (regs[5] !== 32'h0000ABCD) begin
      failures++; $display("FAIL mfhi_r5: got %h required %h", regs[5], 32'h0000ABCD);
    end
  endtask

  task automatic test_mem();
    logic [30:0] seq [$];
    IR_Data = 32'h00800010;  // ld R1,0x10
    seq = '{F1, F2, RUN|GRB|BAO|Y_EN, RUN|S_C|A_ADD|Z_EN, RUN|S_ZLO|MAR_EN,
            RUN|RD|MDR_EN, RUN|S_MDR|GRA|R_EN, F0};
    foreach (seq[i]) begin
      tick(); checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL ld step %0d: got %h required %h", i, obs, seq[i]);
      end
    end
    IR_Data = 32'h10800010;  // st 0x10,R1
    seq = '{F1, F2, RUN|GRB|BAO|Y_EN, RUN|S_C|A_ADD|Z_EN, RUN|S_ZLO|MAR_EN,
            RUN|GRA|S_R|MDR_EN, RUN|WR, F0};
    foreach (seq[i]) begin
      tick(); checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL st step %0d: got %h required %h", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [30:0] seq [$];
    for (int c = 0; c < 2; c++) begin
      con_output = c[0];
      IR_Data = 32'h90800010;  // brx R1,0x10
      seq = '{F1, F2, RUN|GRA|S_R|CON_EN, RUN|S_PC|Y_EN, RUN|S_C|A_ADD|Z_EN,
              (c == 1) ? (RUN|S_ZLO|PC_EN) : (RUN|S_ZLO), F0};
      foreach (seq[i]) begin
        tick(); checks++;
        if (obs !== seq[i]) begin
          failures++;
          $display("FAIL brx con=%0d step %0d: got %h required %h", c, i, obs, seq[i]);
        end
      end
    end
    con_output = 1'b0;
    IR_Data = 32'h98800000;  // jr R1
    seq = '{F1, F2, RUN|GRA|S_R|PC_EN, F0};
    foreach (seq[i]) begin
      tick(); checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL jr step %0d: got %h required %h", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_stop_mul();
    logic [30:0] seq [$];
    IR_Data = 32'h79180000;  // mul R2,R3
    seq = '{F1, F2, RUN|GRA|S_R|Y_EN, RUN|GRB|S_R|A_MUL|Z_EN, RUN|S_ZLO|LO_EN,
            RUN|S_ZHI|HI_EN, 31'h0, F0};
    foreach (seq[i]) begin
      tick(); checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL mul_stop step %0d: got %h required %h", i, obs, seq[i]);
      end
      stop = (i == 3);  // one-cycle pulse during T4
    end
  endtask

  task automatic test_halt_nop();
    logic [30:0] seq [$];
    logic [31:0] irs [3] = '{32'hD8000000, 32'hD0000000, 32'hF8000000};
    for (int k = 0; k < 3; k++) begin
      IR_Data = irs[k];
      if (k == 0) seq = '{F1, F2, 31'h0, F0};
      else        seq = '{F1, F2, F0};
      foreach (seq[i]) begin
        tick(); checks++;
        if (obs !== seq[i]) begin
          failures++;
          $display("FAIL halt_nop ir=%h step %0d: got %h required %h", irs[k], i, obs, seq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    IR_Data = 32'h18918000;
    tick(); checks++;
    if (obs !== F1) begin
      failures++; $display("FAIL midreset_f1: got %h required %h", obs, F1);
    end
    #2 reset_n = 1'b0;
    #1 checks++;
    if (obs !== 31'h0) begin
      failures++; $display("FAIL midreset_async: got %h required %h", obs, 31'h0);
    end
    @(negedge clk); reset_n = 1'b1;
    tick(); checks++;
    if (obs !== 31'h0) begin
      failures++; $display("FAIL midreset_hold: got %h required %h", obs, 31'h0);
    end
    tick(); checks++;
    if (obs !== F0) begin
      failures++; $display("FAIL midreset_fetch0: got %h required %h", obs, F0);
    end
  endtask

  initial begin
    test_reset();
    test_reg_alu();
    test_ldi_mfhi();
    test_mem();
    test_branch();
    test_stop_mul();
    test_halt_nop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
